// File: rtl/cpu_mc_if.sv
// Instruction and data memory request/ready ports of the multi-cycle core.
// The core drives requests through master; memory models connect through slave.
interface cpu_mc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  dmem_op;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_op, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_op, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I core: FETCH -> EXEC -> (MEM) -> FETCH, sticky HALT on ebreak/illegal.
// Memory ports are variable-latency request/ready handshakes.
module cpu_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  cpu_mc_if.master         mem,
  output logic             halted,
  output logic [31:0]      dbgdata,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  logic [31:0] pc, ir;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, alu_b, alu_y, sra_y, wb_y, next_pc, pc_plus4;
  logic        is_ld, is_st, legal, halt_dec, writes_rd, take, rf_we;
  logic [31:0] rf_wd;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rs1v     = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2v     = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign pc_plus4 = pc + 32'd4;

  assign is_ld = (opcode == OP_LOAD);
  assign is_st = (opcode == OP_STORE);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign halt_dec  = !legal || (ir == EBREAK);
  assign writes_rd = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                     (opcode == OP_JALR) || (opcode == OP_OP) || (opcode == OP_OPIMM);

  // Kept as its own signal so the arithmetic shift stays in a signed context.
  assign alu_b = (opcode == OP_OP) ? rs2v : imm_i;
  assign sra_y = $signed(rs1v) >>> alu_b[4:0];

  always_comb begin
    alu_y = 32'd0;
    case (funct3)
      3'b000: alu_y = (opcode == OP_OP && ir[30]) ? rs1v - alu_b : rs1v + alu_b;
      3'b001: alu_y = rs1v << alu_b[4:0];
      3'b010: alu_y = {31'b0, $signed(rs1v) < $signed(alu_b)};
      3'b011: alu_y = {31'b0, rs1v < alu_b};
      3'b100: alu_y = rs1v ^ alu_b;
      3'b101: alu_y = ir[30] ? sra_y : (rs1v >> alu_b[4:0]);
      3'b110: alu_y = rs1v | alu_b;
      3'b111: alu_y = rs1v & alu_b;
      default: alu_y = 32'd0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000: take = (rs1v == rs2v);
      3'b001: take = (rs1v != rs2v);
      3'b100: take = $signed(rs1v) <  $signed(rs2v);
      3'b101: take = $signed(rs1v) >= $signed(rs2v);
      3'b110: take = rs1v <  rs2v;
      3'b111: take = rs1v >= rs2v;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (opcode == OP_JAL)                 next_pc = pc + imm_j;
    else if (opcode == OP_JALR)           next_pc = (rs1v + imm_i) & ~32'd1;
    else if (opcode == OP_BRANCH && take) next_pc = pc + imm_b;
  end

  always_comb begin
    case (opcode)
      OP_LUI:           wb_y = imm_u;
      OP_AUIPC:         wb_y = pc + imm_u;
      OP_JAL, OP_JALR:  wb_y = pc_plus4;
      default:          wb_y = alu_y;
    endcase
  end

  // Requests are gated by reset so an in-flight access drops immediately.
  assign mem.imem_req   = reset && (state == FETCH);
  assign mem.imem_addr  = pc;
  assign mem.dmem_req   = reset && (state == MEM);
  assign mem.dmem_we    = is_st;
  assign mem.dmem_op    = funct3;
  assign mem.dmem_addr  = rs1v + (is_st ? imm_s : imm_i);
  assign mem.dmem_wdata = rs2v;
  assign dbgdata        = pc;

  assign rf_we = (rd != 5'd0) &&
                 (((state == EXEC) && !halt_dec && !is_ld && !is_st && writes_rd) ||
                  ((state == MEM) && mem.dmem_ready && is_ld));
  assign rf_wd = (state == MEM) ? mem.dmem_rdata : wb_y;

  always_ff @(posedge clock) begin
    if (rf_we) rf[rd] <= rf_wd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      instret <= '0;
      halted  <= 1'b0;
    end else begin
      case (state)
        FETCH: if (mem.imem_ready) begin
          ir    <= mem.imem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          if (halt_dec) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (is_ld || is_st) begin
            state <= MEM;
          end else begin
            pc      <= next_pc;
            instret <= instret + CNT_ONE;
            state   <= FETCH;
          end
        end
        MEM: if (mem.dmem_ready) begin
          pc      <= pc_plus4;
          instret <= instret + CNT_ONE;
          state   <= FETCH;
        end
        HALT: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: a table of single-instruction vectors plus
// hand sequences for wait states, halt and reset during a data access.
module tb_cpu_mc;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        halted;
  logic [31:0] dbgdata;
  logic [31:0] instret;

  int n_chk = 0;
  int n_fail = 0;
  int exp_instret = 0;

  cpu_mc_if mem_if();

  cpu_mc #(.RESET_PC(32'h100), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .mem(mem_if.master),
    .halted(halted), .dbgdata(dbgdata), .instret(instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Serve one fetch after 'waits' idle cycles, then pass through EXEC.
  task automatic fetch(input string nm, input logic [31:0] pc, input logic [31:0] instr,
                       input int waits);
    for (int w = 0; w <= waits; w++) begin
      chk({nm, "_ireq"}, {31'b0, mem_if.imem_req}, 32'd1);
      chk({nm, "_iaddr"}, mem_if.imem_addr, pc);
      if (w == waits) begin
        mem_if.imem_ready = 1'b1;
        mem_if.imem_rdata = instr;
      end
      step();
    end
    mem_if.imem_ready = 1'b0;
    mem_if.imem_rdata = 32'h0;
    chk({nm, "_exec_idle"}, {30'b0, mem_if.imem_req, mem_if.dmem_req}, 32'd0);
    step();
  endtask

  task automatic mem_acc(input string nm, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    for (int w = 0; w <= waits; w++) begin
      chk({nm, "_dreq"}, {30'b0, mem_if.dmem_req, mem_if.imem_req}, 32'd2);
      chk({nm, "_dwe"}, {31'b0, mem_if.dmem_we}, {31'b0, we});
      chk({nm, "_daddr"}, mem_if.dmem_addr, addr);
      chk({nm, "_dop"}, {29'b0, mem_if.dmem_op}, 32'd2);
      if (we) chk({nm, "_dwdata"}, mem_if.dmem_wdata, wdata);
      if (w == waits) begin
        mem_if.dmem_ready = 1'b1;
        mem_if.dmem_rdata = rdata;
      end
      step();
    end
    mem_if.dmem_ready = 1'b0;
    mem_if.dmem_rdata = 32'h0;
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("v%0d", i);
    fetch(nm, vt[i].pc, vt[i].instr, 0);
    if (vt[i].mem) mem_acc(nm, vt[i].we, vt[i].addr, vt[i].wdata, 32'h0, 0);
    exp_instret++;
    chk({nm, "_instret"}, instret, exp_instret);
    chk({nm, "_next_pc"}, mem_if.imem_addr, vt[i].next_pc);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0;
    #1;
    chk({nm, "_rst_reqs"}, {30'b0, mem_if.imem_req, mem_if.dmem_req}, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_instret = 0;
    chk({nm, "_ireq"}, {31'b0, mem_if.imem_req}, 32'd1);
    chk({nm, "_iaddr"}, mem_if.imem_addr, 32'h100);
    chk({nm, "_dbg"}, dbgdata, 32'h100);
    chk({nm, "_instret"}, instret, 32'd0);
    chk({nm, "_halted"}, {31'b0, halted}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    mem_if.imem_ready = 1'b0; mem_if.imem_rdata = 32'h0;
    mem_if.dmem_ready = 1'b0; mem_if.dmem_rdata = 32'h0;

    //            pc        instr          mem   we    addr    wdata          next
    vt[0]  = '{32'h100, 32'h00500093, 1'b0, 1'b0, 32'h0,  32'h0,         32'h104}; // addi x1,x0,5
    vt[1]  = '{32'h104, 32'hFF908113, 1'b0, 1'b0, 32'h0,  32'h0,         32'h108}; // addi x2,x1,-7
    vt[2]  = '{32'h108, 32'h00202023, 1'b1, 1'b1, 32'h0,  32'hFFFF_FFFE, 32'h10C}; // sw x2,0(x0)
    vt[3]  = '{32'h110, 32'hFE000CE3, 1'b0, 1'b0, 32'h0,  32'h0,         32'h108}; // beq x0,x0,-8
    vt[4]  = '{32'h108, 32'h00302423, 1'b1, 1'b1, 32'h8,  32'hDEAD_BEEF, 32'h10C}; // sw x3,8(x0)
    vt[5]  = '{32'h10C, 32'h20000293, 1'b0, 1'b0, 32'h0,  32'h0,         32'h110}; // addi x5,x0,0x200
    vt[6]  = '{32'h110, 32'hFE001CE3, 1'b0, 1'b0, 32'h0,  32'h0,         32'h114}; // bne x0,x0,-8
    vt[7]  = '{32'h114, 32'h003280E7, 1'b0, 1'b0, 32'h0,  32'h0,         32'h202}; // jalr x1,3(x5)
    vt[8]  = '{32'h202, 32'h00102623, 1'b1, 1'b1, 32'hC,  32'h118,       32'h206}; // sw x1,12(x0)
    vt[9]  = '{32'h206, 32'h12345337, 1'b0, 1'b0, 32'h0,  32'h0,         32'h20A}; // lui x6,0x12345
    vt[10] = '{32'h20A, 32'h401303B3, 1'b0, 1'b0, 32'h0,  32'h0,         32'h20E}; // sub x7,x6,x1
    vt[11] = '{32'h20E, 32'h00702823, 1'b1, 1'b1, 32'h10, 32'h12344EE8,  32'h212}; // sw x7,16(x0)
    vt[12] = '{32'h212, 32'h0200006F, 1'b0, 1'b0, 32'h0,  32'h0,         32'h232}; // jal x0,+0x20
    vt[13] = '{32'h232, 32'h40115413, 1'b0, 1'b0, 32'h0,  32'h0,         32'h236}; // srai x8,x2,1
    vt[14] = '{32'h236, 32'h00802A23, 1'b1, 1'b1, 32'h14, 32'hFFFF_FFFF, 32'h23A}; // sw x8,20(x0)
    vt[15] = '{32'h23A, 32'h00100013, 1'b0, 1'b0, 32'h0,  32'h0,         32'h23E}; // addi x0,x0,1
    vt[16] = '{32'h23E, 32'h00002C23, 1'b1, 1'b1, 32'h18, 32'h0,         32'h242}; // sw x0,24(x0)

    @(negedge clock);
    do_reset("rst0");

    for (int i = 0; i < 3; i++) run_vec(i);
    chk("alu_seq_instret", instret, 32'd3);

    // lw x3,4(x0) with a 2-cycle fetch stall and 3 data wait states
    fetch("lw", 32'h10C, 32'h00402183, 2);
    mem_acc("lw", 1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF, 3);
    exp_instret++;
    chk("lw_instret", instret, exp_instret);
    chk("lw_dreq_drop", {31'b0, mem_if.dmem_req}, 32'd0);
    chk("lw_next_pc", mem_if.imem_addr, 32'h110);

    for (int i = 3; i < 17; i++) run_vec(i);

    // ebreak: halt one edge after EXEC, no further requests even with ready high
    fetch("ebrk", 32'h242, 32'h0010_0073, 0);
    chk("ebrk_halted", {31'b0, halted}, 32'd1);
    bad = 1'b0;
    mem_if.imem_ready = 1'b1;
    mem_if.dmem_ready = 1'b1;
    repeat (20) begin
      bad |= mem_if.imem_req | mem_if.dmem_req;
      step();
    end
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;
    chk("ebrk_noreq", {31'b0, bad}, 32'd0);
    chk("ebrk_halted_hold", {31'b0, halted}, 32'd1);
    chk("ebrk_dbg", dbgdata, 32'h242);
    chk("ebrk_instret", instret, 32'd18);

    // all-zero word is an illegal opcode
    do_reset("rst1");
    fetch("ill", 32'h100, 32'h0000_0000, 0);
    chk("ill_halted", {31'b0, halted}, 32'd1);
    bad = 1'b0;
    repeat (5) begin
      bad |= mem_if.imem_req | mem_if.dmem_req;
      step();
    end
    chk("ill_noreq", {31'b0, bad}, 32'd0);
    chk("ill_dbg", dbgdata, 32'h100);
    chk("ill_instret", instret, 32'd0);

    // reset asserted while a load waits in MEM
    do_reset("rst2");
    fetch("mrst", 32'h100, 32'h00402183, 0);
    chk("mrst_dreq", {31'b0, mem_if.dmem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mrst_dreq_async", {31'b0, mem_if.dmem_req}, 32'd0);
    mem_if.dmem_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    mem_if.dmem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst_iaddr", mem_if.imem_addr, 32'h100);
    chk("mrst_ireq", {30'b0, mem_if.imem_req, mem_if.dmem_req}, 32'd2);
    chk("mrst_instret", instret, 32'd0);
    exp_instret = 0;
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
